// File: rtl/dum_pkg.sv
// rtl/dum_pkg.sv - shared types for the drive/use monitor
//
// Purpose: event and sweep-state types shared by drive_use_monitor and its
// event FIFO, plus a small constructor for queue entries.
// Ports: none (package).

package dum_pkg;

  // Queue entries carry a fixed-width address field; the monitor zero-extends
  // its register index into it, so up to 256 registers are representable.
  localparam int MAX_ADDR_W = 8;

  typedef enum logic [1:0] {
    UNDRIVEN_READ = 2'd0,
    MULTI_DRIVEN  = 2'd1,
    UNUSED        = 2'd2
  } evt_type_e;

  typedef struct packed {
    evt_type_e              etype;
    logic [MAX_ADDR_W-1:0]  addr;
  } evt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } sweep_state_e;

  function automatic evt_t make_evt(input evt_type_e t, input logic [MAX_ADDR_W-1:0] a);
    evt_t e;
    e.etype = t;
    e.addr  = a;
    return e;
  endfunction

endpackage

// File: rtl/dum_evt_fifo.sv
// rtl/dum_evt_fifo.sv - event FIFO with a two-entry push port
//
// Purpose: holds monitor events in arrival order. Up to two entries can be
// pushed per cycle; lane 1 is only used when lane 0 is also used.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          synchronous flush (wins over push/pop)
//   push_valid[1:0], push_data[1:0]   push lanes, lane 0 enters first
//   pop            remove head entry (ignored when empty)
//   head_valid, head_data             oldest entry
//   space          free entries before this cycle's pop

module dum_evt_fifo
  import dum_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [1:0]                push_valid,
  input  evt_t [1:0]                push_data,
  input  logic                      pop,
  output logic                      head_valid,
  output evt_t                      head_data,
  output logic [$clog2(DEPTH):0]    space
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  evt_t           mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  wr_ptr_1;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [1:0]     n_push;
  logic           pop_ok;

  assign wr_ptr_1   = wr_ptr + 1'b1;
  assign n_push     = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
  assign head_valid = (count != '0);
  assign pop_ok     = pop & head_valid;
  assign head_data  = mem[rd_ptr];
  assign space      = CW'(DEPTH) - count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      wr_ptr <= wr_ptr + PW'(n_push);
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(n_push) - CW'(pop_ok);
    end
  end

  // Storage carries no reset: entries are only observable through head_valid.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_valid[0]) mem[wr_ptr]   <= push_data[0];
      if (push_valid[1]) mem[wr_ptr_1] <= push_data[1];
    end
  end

endmodule

// File: rtl/drive_use_monitor.sv
// rtl/drive_use_monitor.sv - runtime per-bit drive/use tracking monitor
//
// Purpose: shadow register bank recording, per bit, whether it was ever
// driven and ever used. Reports undriven reads and multi-source drives as
// they happen, and driven-but-unused registers on an on-demand sweep.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   clear                      synchronous clear of data, masks, queue, flags
//   wr_valid/addr/data/be[1:0] two write sources; source 0 wins overlaps
//   rd_req, rd_addr, rd_be     read request and bits consumed
//   rd_rsp_valid, rd_data, rd_undriven   response, one cycle after request
//   sweep_start/busy/done      unused-bit sweep control and status
//   evt_valid/ready/type/addr  event queue head, popped on valid & ready
//   evt_overflow               sticky: a read/write event was dropped

module drive_use_monitor
  import dum_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int DATA_W    = 8,
  parameter int EVT_DEPTH = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [1:0]              wr_valid,
  input  logic [1:0][AW-1:0]      wr_addr,
  input  logic [1:0][DATA_W-1:0]  wr_data,
  input  logic [1:0][DATA_W-1:0]  wr_be,
  input  logic                    rd_req,
  input  logic [AW-1:0]           rd_addr,
  input  logic [DATA_W-1:0]       rd_be,
  output logic                    rd_rsp_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic [DATA_W-1:0]       rd_undriven,
  input  logic                    sweep_start,
  output logic                    sweep_busy,
  output logic                    sweep_done,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [1:0]              evt_type,
  output logic [AW-1:0]           evt_addr,
  output logic                    evt_overflow
);

  localparam int CW  = $clog2(EVT_DEPTH) + 1;
  localparam int CW1 = CW + 1;
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  // Shadow state
  logic [DATA_W-1:0] data_q   [NUM_REGS];
  logic [DATA_W-1:0] drv_q    [NUM_REGS];
  logic [DATA_W-1:0] used_q   [NUM_REGS];
  logic [1:0]        seen_q   [NUM_REGS];
  logic [DATA_W-1:0] data_nxt [NUM_REGS];
  logic [DATA_W-1:0] drv_nxt  [NUM_REGS];
  logic [DATA_W-1:0] used_nxt [NUM_REGS];
  logic [1:0]        seen_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] multi_hit;

  // Sweep state
  sweep_state_e      state;
  logic [AW-1:0]     ptr;
  logic [DATA_W-1:0] unused_bits;

  // Event path
  logic              evt_pop;
  logic [CW-1:0]     fifo_space;
  logic [CW1-1:0]    avail;
  logic [1:0]        lane_cap;
  logic [1:0]        n_lane;
  logic [2:0]        cand_v;
  evt_t              cand_d [3];
  logic [1:0]        push_v;
  evt_t [1:0]        push_d;
  logic              path_drop;
  logic              emit_ok;
  logic              head_valid;
  evt_t              head;
  logic              unused_head_addr;

  logic [DATA_W-1:0] rd_undriven_now;

  // Next-state of the shadow bank. Reads see the registered (pre-write) values.
  always_comb begin
    for (int a = 0; a < NUM_REGS; a++) begin
      data_nxt[a] = data_q[a];
      drv_nxt[a]  = drv_q[a];
      seen_nxt[a] = seen_q[a];
      used_nxt[a] = used_q[a];
      // Source 1 is applied first so source 0 overrides overlapping bits.
      for (int s = 1; s >= 0; s--) begin
        if (wr_valid[s] && (wr_addr[s] == AW'(a))) begin
          data_nxt[a]    = (data_nxt[a] & ~wr_be[s]) | (wr_data[s] & wr_be[s]);
          drv_nxt[a]     = drv_nxt[a] | wr_be[s];
          seen_nxt[a][s] = 1'b1;
        end
      end
      if (rd_req && (rd_addr == AW'(a))) used_nxt[a] = used_q[a] | rd_be;
      // Once both sources are seen the pair stays set, so this fires once per address.
      multi_hit[a] = (seen_nxt[a] == 2'b11) && (seen_q[a] != 2'b11);
    end
  end

  assign rd_undriven_now = rd_be & ~drv_q[rd_addr];

  // Candidate path events in enqueue order: MULTI_DRIVEN (by source), then UNDRIVEN_READ.
  assign cand_v[0] = wr_valid[0] && multi_hit[wr_addr[0]];
  assign cand_v[1] = wr_valid[1] && multi_hit[wr_addr[1]]
                     && !(wr_valid[0] && (wr_addr[0] == wr_addr[1]));
  assign cand_v[2] = rd_req && (rd_undriven_now != '0);
  assign cand_d[0] = make_evt(MULTI_DRIVEN,  MAX_ADDR_W'(wr_addr[0]));
  assign cand_d[1] = make_evt(MULTI_DRIVEN,  MAX_ADDR_W'(wr_addr[1]));
  assign cand_d[2] = make_evt(UNDRIVEN_READ, MAX_ADDR_W'(rd_addr));

  // A same-cycle pop frees a slot, so a full queue can still accept a push.
  assign evt_pop  = head_valid & evt_ready;
  assign avail    = {1'b0, fifo_space} + CW1'(evt_pop);
  assign lane_cap = (avail >= CW1'(2)) ? 2'd2 : avail[1:0];

  // Pack accepted events into the push lanes. Path events beyond the
  // capacity are dropped; the sweep only takes whatever slot is left.
  always_comb begin
    push_v    = '0;
    push_d    = '0;
    n_lane    = '0;
    path_drop = 1'b0;
    emit_ok   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (cand_v[k]) begin
        if (n_lane < lane_cap) begin
          push_v[n_lane[0]] = 1'b1;
          push_d[n_lane[0]] = cand_d[k];
          n_lane            = n_lane + 2'd1;
        end else begin
          path_drop = 1'b1;
        end
      end
    end
    if ((state == EMIT) && (n_lane < lane_cap)) begin
      push_v[n_lane[0]] = 1'b1;
      push_d[n_lane[0]] = make_evt(UNUSED, MAX_ADDR_W'(ptr));
      emit_ok           = 1'b1;
    end
  end

  dum_evt_fifo #(
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .push_valid (push_v),
    .push_data  (push_d),
    .pop        (evt_pop),
    .head_valid (head_valid),
    .head_data  (head),
    .space      (fifo_space)
  );

  assign evt_valid = head_valid;
  assign evt_type  = head_valid ? head.etype : 2'd0;
  assign evt_addr  = head_valid ? head.addr[AW-1:0] : '0;
  assign unused_head_addr = ^head.addr;

  // Shadow bank, read response and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < NUM_REGS; a++) begin
        data_q[a] <= '0;
        drv_q[a]  <= '0;
        used_q[a] <= '0;
        seen_q[a] <= '0;
      end
      rd_rsp_valid <= 1'b0;
      rd_data      <= '0;
      rd_undriven  <= '0;
      evt_overflow <= 1'b0;
    end else if (clear) begin
      for (int a = 0; a < NUM_REGS; a++) begin
        data_q[a] <= '0;
        drv_q[a]  <= '0;
        used_q[a] <= '0;
        seen_q[a] <= '0;
      end
      rd_rsp_valid <= 1'b0;
      rd_data      <= '0;
      rd_undriven  <= '0;
      evt_overflow <= 1'b0;
    end else begin
      for (int a = 0; a < NUM_REGS; a++) begin
        data_q[a] <= data_nxt[a];
        drv_q[a]  <= drv_nxt[a];
        used_q[a] <= used_nxt[a];
        seen_q[a] <= seen_nxt[a];
      end
      rd_rsp_valid <= rd_req;
      if (rd_req) begin
        rd_data     <= data_q[rd_addr] & drv_q[rd_addr];
        rd_undriven <= rd_undriven_now;
      end
      if (path_drop) evt_overflow <= 1'b1;
    end
  end

  // Unused-bit sweep
  assign unused_bits = drv_q[ptr] & ~used_q[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      ptr        <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state      <= SCAN;
            ptr        <= '0;
            sweep_busy <= 1'b1;
          end
        end
        SCAN: begin
          if (unused_bits != '0) begin
            state <= EMIT;
          end else if (ptr == LAST) begin
            state      <= DONE;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        EMIT: begin
          // Stall here until the queue has room; UNUSED events are never dropped.
          if (emit_ok) begin
            if (ptr == LAST) begin
              state      <= DONE;
              sweep_busy <= 1'b0;
              sweep_done <= 1'b1;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drive_use_monitor.sv
// tb/tb_drive_use_monitor.sv - self-checking bench for drive_use_monitor
module tb_drive_use_monitor;
  import dum_pkg::*;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear;
  logic [1:0]          wr_valid;
  logic [1:0][AW-1:0]  wr_addr;
  logic [1:0][W-1:0]   wr_data;
  logic [1:0][W-1:0]   wr_be;
  logic                rd_req;
  logic [AW-1:0]       rd_addr;
  logic [W-1:0]        rd_be;
  logic                rd_rsp_valid;
  logic [W-1:0]        rd_data;
  logic [W-1:0]        rd_undriven;
  logic                sweep_start, sweep_busy, sweep_done;
  logic                evt_valid, evt_ready;
  logic [1:0]          evt_type;
  logic [AW-1:0]       evt_addr;
  logic                evt_overflow;

  int vectors = 0;
  int miscompares = 0;

  drive_use_monitor #(.NUM_REGS(N), .DATA_W(W), .EVT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_be(rd_be),
    .rd_rsp_valid(rd_rsp_valid), .rd_data(rd_data), .rd_undriven(rd_undriven),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_addr(evt_addr), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: per-register data, masks, sources seen; events as type*256+addr.
  logic [W-1:0] m_data [N];
  logic [W-1:0] m_drv  [N];
  logic [W-1:0] m_used [N];
  logic [1:0]   m_seen [N];
  int           m_q [$];
  bit           m_ovf;
  bit           m_rsp_v;
  logic [W-1:0] m_rsp_data, m_rsp_und;

  task automatic model_clear();
    for (int a = 0; a < N; a++) begin
      m_data[a] = '0; m_drv[a] = '0; m_used[a] = '0; m_seen[a] = '0;
    end
    m_q.delete();
    m_ovf = 0; m_rsp_v = 0; m_rsp_data = '0; m_rsp_und = '0;
  endtask

  task automatic idle_inputs();
    clear = 0; wr_valid = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_req = 0; rd_addr = '0; rd_be = '0; sweep_start = 0;
  endtask

  // Advance the model by one cycle of the current inputs, then clock the DUT.
  task automatic tick();
    int evs[$];
    logic [1:0] after;
    int acc;
    if (clear) begin
      model_clear();
    end else begin
      if (evt_ready && m_q.size() > 0) void'(m_q.pop_front());
      for (int s = 0; s < 2; s++) begin
        int a;
        if (!wr_valid[s]) continue;
        if (s == 1 && wr_valid[0] && wr_addr[0] == wr_addr[1]) continue;
        a = int'(wr_addr[s]);
        after = m_seen[a];
        for (int t = 0; t < 2; t++) if (wr_valid[t] && int'(wr_addr[t]) == a) after[t] = 1'b1;
        if (after == 2'b11 && m_seen[a] != 2'b11) evs.push_back(256 + a);
      end
      m_rsp_v = rd_req;
      if (rd_req) begin
        m_rsp_data = m_data[rd_addr] & m_drv[rd_addr];
        m_rsp_und  = rd_be & ~m_drv[rd_addr];
        if (m_rsp_und != 0) evs.push_back(int'(rd_addr));
        m_used[rd_addr] = m_used[rd_addr] | rd_be;
      end
      for (int a = 0; a < N; a++)
        for (int b = 0; b < W; b++)
          if (wr_valid[0] && int'(wr_addr[0]) == a && wr_be[0][b]) m_data[a][b] = wr_data[0][b];
          else if (wr_valid[1] && int'(wr_addr[1]) == a && wr_be[1][b]) m_data[a][b] = wr_data[1][b];
      for (int s = 0; s < 2; s++) if (wr_valid[s]) begin
        m_seen[wr_addr[s]][s] = 1'b1;
        m_drv[wr_addr[s]] = m_drv[wr_addr[s]] | wr_be[s];
      end
      // At most two events enter the queue per cycle, and only while space remains.
      acc = 0;
      foreach (evs[i]) begin
        if (m_q.size() < D && acc < 2) begin m_q.push_back(evs[i]); acc++; end
        else m_ovf = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors += 6;
    if (rd_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rd_rsp_valid); end
    if (rd_data !== 8'h00 || rd_undriven !== 8'h00) begin miscompares++; $display("FAIL reset_rd got %h/%h exp 00/00", rd_data, rd_undriven); end
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_evt_valid got %b exp 0", evt_valid); end
    if (evt_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b exp 0", evt_overflow); end
    if (sweep_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", sweep_busy); end
    if (sweep_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", sweep_done); end
  endtask

  task automatic test_async_reset();
    rd_req = 1; rd_addr = 3'd4; rd_be = 8'hFF;
    tick();
    rd_req = 0;
    #2 rst_n = 0;
    #1;
    vectors += 2;
    if (rd_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_rsp got %b exp 0", rd_rsp_valid); end
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_evt got %b exp 0", evt_valid); end
    @(posedge clk); #1 rst_n = 1;
    model_clear();
  endtask

  task automatic test_undriven_read();
    rd_req = 1; rd_addr = 3'd3; rd_be = 8'hFF;
    tick();
    rd_req = 0;
    vectors += 3;
    if (rd_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL undr_rsp_valid got %b exp 1", rd_rsp_valid); end
    if (rd_data !== 8'h00 || rd_undriven !== 8'hFF) begin miscompares++; $display("FAIL undr_rd got %h/%h exp 00/ff", rd_data, rd_undriven); end
    if (evt_valid !== 1'b1 || evt_type !== 2'd0 || evt_addr !== 3'd3) begin miscompares++; $display("FAIL undr_evt got %b %0d %0d exp 1 0 3", evt_valid, evt_type, evt_addr); end
    evt_ready = 1; tick(); evt_ready = 0;
    vectors++;
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL undr_pop got %b exp 0", evt_valid); end
  endtask

  task automatic test_partial_write();
    wr_valid = 2'b01; wr_addr[0] = 3'd1; wr_data[0] = 8'hA5; wr_be[0] = 8'h0F;
    tick();
    wr_valid = '0;
    rd_req = 1; rd_addr = 3'd1; rd_be = 8'hFF;
    tick();
    rd_req = 0;
    vectors += 2;
    if (rd_data !== 8'h05 || rd_undriven !== 8'hF0) begin miscompares++; $display("FAIL partial_rd got %h/%h exp 05/f0", rd_data, rd_undriven); end
    if (evt_valid !== 1'b1 || evt_type !== 2'd0 || evt_addr !== 3'd1) begin miscompares++; $display("FAIL partial_evt got %b %0d %0d exp 1 0 1", evt_valid, evt_type, evt_addr); end
    evt_ready = 1; tick(); evt_ready = 0;
  endtask

  task automatic test_multi_driven();
    wr_valid = 2'b11; wr_addr[0] = 3'd2; wr_addr[1] = 3'd2;
    wr_data[0] = 8'h11; wr_data[1] = 8'h22; wr_be[0] = 8'hFF; wr_be[1] = 8'hFF;
    tick();
    wr_valid = '0;
    vectors++;
    if (evt_valid !== 1'b1 || evt_type !== 2'd1 || evt_addr !== 3'd2) begin miscompares++; $display("FAIL multi_evt got %b %0d %0d exp 1 1 2", evt_valid, evt_type, evt_addr); end
    evt_ready = 1;
    rd_req = 1; rd_addr = 3'd2; rd_be = 8'hFF;
    tick();
    rd_req = 0;
    vectors += 2;
    if (rd_data !== 8'h11 || rd_undriven !== 8'h00) begin miscompares++; $display("FAIL multi_rd got %h/%h exp 11/00", rd_data, rd_undriven); end
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL multi_once got %b exp 0", evt_valid); end
    wr_valid = 2'b10; wr_addr[1] = 3'd2; wr_data[1] = 8'h33; wr_be[1] = 8'hFF;
    tick();
    wr_valid = '0;
    vectors++;
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL multi_repeat got %b exp 0", evt_valid); end
    evt_ready = 0;
  endtask

  task automatic test_overflow_clear();
    evt_ready = 0;
    rd_addr = 3'd7; rd_be = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      rd_req = 1;
      tick();
      vectors++;
      if (evt_overflow !== (i == 4)) begin miscompares++; $display("FAIL ovf_read%0d got %b exp %b", i, evt_overflow, (i == 4)); end
    end
    rd_req = 0;
    clear = 1; tick(); clear = 0;
    vectors += 2;
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL clear_evt got %b exp 0", evt_valid); end
    if (evt_overflow !== 1'b0) begin miscompares++; $display("FAIL clear_ovf got %b exp 0", evt_overflow); end
    rd_req = 1; rd_addr = 3'd2; rd_be = 8'hFF;
    tick(); rd_req = 0;
    vectors++;
    if (rd_data !== 8'h00 || rd_undriven !== 8'hFF) begin miscompares++; $display("FAIL clear_masks got %h/%h exp 00/ff", rd_data, rd_undriven); end
    clear = 1; tick(); clear = 0;
  endtask

  task automatic test_sweep();
    int n_evt, n_done, ev_type, ev_addr;
    wr_valid = 2'b11; wr_addr[0] = 3'd0; wr_addr[1] = 3'd5;
    wr_data[0] = 8'h3C; wr_data[1] = 8'hC3; wr_be[0] = 8'hFF; wr_be[1] = 8'hFF;
    tick();
    wr_valid = '0;
    rd_req = 1; rd_addr = 3'd0; rd_be = 8'hFF;
    tick();
    rd_req = 0;
    evt_ready = 1; sweep_start = 1;
    @(posedge clk); #1;
    sweep_start = 0;
    vectors++;
    if (sweep_busy !== 1'b1) begin miscompares++; $display("FAIL sweep_busy_start got %b exp 1", sweep_busy); end
    n_evt = 0; n_done = 0; ev_type = -1; ev_addr = -1;
    for (int c = 0; c < 40; c++) begin
      if (evt_valid) begin n_evt++; ev_type = int'(evt_type); ev_addr = int'(evt_addr); end
      if (sweep_done) n_done++;
      @(posedge clk); #1;
    end
    vectors += 4;
    if (n_evt != 1) begin miscompares++; $display("FAIL sweep_evt_count got %0d exp 1", n_evt); end
    if (ev_type != 2 || ev_addr != 5) begin miscompares++; $display("FAIL sweep_evt got %0d %0d exp 2 5", ev_type, ev_addr); end
    if (n_done != 1) begin miscompares++; $display("FAIL sweep_done_pulses got %0d exp 1", n_done); end
    if (sweep_busy !== 1'b0) begin miscompares++; $display("FAIL sweep_busy_end got %b exp 0", sweep_busy); end
    evt_ready = 0;
    clear = 1; tick(); clear = 0;
  endtask

  task automatic test_clear_mid_sweep();
    int n_done;
    evt_ready = 0;
    rd_addr = 3'd0; rd_be = 8'hFF;
    for (int i = 0; i < 4; i++) begin rd_req = 1; tick(); end
    rd_req = 0;
    for (int a = 1; a < N; a++) begin
      wr_valid = 2'b01; wr_addr[0] = AW'(a); wr_data[0] = 8'h5A; wr_be[0] = 8'hFF;
      tick();
    end
    wr_valid = '0;
    sweep_start = 1; tick(); sweep_start = 0;
    repeat (3) tick();
    vectors += 2;
    if (sweep_busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy got %b exp 1", sweep_busy); end
    if (evt_overflow !== 1'b0 || evt_valid !== 1'b1) begin miscompares++; $display("FAIL stall_queue got ovf %b valid %b exp 0 1", evt_overflow, evt_valid); end
    clear = 1; tick(); clear = 0;
    vectors += 3;
    if (sweep_busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b exp 0", sweep_busy); end
    if (sweep_done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b exp 0", sweep_done); end
    if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL abort_evt got %b exp 0", evt_valid); end
    n_done = 0;
    for (int c = 0; c < 12; c++) begin tick(); if (sweep_done) n_done++; end
    vectors++;
    if (n_done != 0) begin miscompares++; $display("FAIL abort_late_done got %0d exp 0", n_done); end
    evt_ready = 1;
    for (int a = 0; a < N; a++) begin
      rd_req = 1; rd_addr = AW'(a); rd_be = 8'hFF;
      tick();
      vectors++;
      if (rd_data !== 8'h00 || rd_undriven !== 8'hFF) begin miscompares++; $display("FAIL abort_mask%0d got %h/%h exp 00/ff", a, rd_data, rd_undriven); end
    end
    rd_req = 0; evt_ready = 0;
    clear = 1; tick(); clear = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clear     = ($urandom_range(0, 59) == 0);
      wr_valid  = 2'($urandom_range(0, 3));
      wr_addr   = {3'($urandom_range(0, N-1)), 3'($urandom_range(0, N-1))};
      wr_data   = 16'($urandom);
      wr_be     = 16'($urandom);
      rd_req    = ($urandom_range(0, 2) != 0);
      rd_addr   = 3'($urandom_range(0, N-1));
      rd_be     = 8'($urandom);
      evt_ready = ($urandom_range(0, 4) < 3);
      tick();
      vectors += 3;
      if (rd_rsp_valid !== m_rsp_v) begin miscompares++; $display("FAIL rnd%0d rsp_valid got %b exp %b", c, rd_rsp_valid, m_rsp_v); end
      else if (m_rsp_v && (rd_data !== m_rsp_data || rd_undriven !== m_rsp_und)) begin
        miscompares++; $display("FAIL rnd%0d rd got %h/%h exp %h/%h", c, rd_data, rd_undriven, m_rsp_data, m_rsp_und);
      end
      if (evt_valid !== (m_q.size() > 0)) begin miscompares++; $display("FAIL rnd%0d evt_valid got %b exp %b", c, evt_valid, (m_q.size() > 0)); end
      else if (m_q.size() > 0 && (evt_type !== 2'(m_q[0] >> 8) || evt_addr !== 3'(m_q[0]))) begin
        miscompares++; $display("FAIL rnd%0d evt got %0d %0d exp %0d %0d", c, evt_type, evt_addr, m_q[0] >> 8, m_q[0] & 255);
      end
      if (evt_overflow !== m_ovf) begin miscompares++; $display("FAIL rnd%0d overflow got %b exp %b", c, evt_overflow, m_ovf); end
    end
    idle_inputs();
    evt_ready = 0;
    clear = 1; tick(); clear = 0;
  endtask

  initial begin
    idle_inputs();
    evt_ready = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_async_reset();
    test_reset();
    test_undriven_read();
    test_partial_write();
    test_multi_driven();
    test_overflow_clear();
    test_sweep();
    test_clear_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
